// File: rtl/superscalar_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : superscalar_issue_queue
//  Description : In-order fetch buffer presenting the three oldest entries,
//                tagged with program-order sequence numbers, to decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module superscalar_issue_queue #(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [1:0]       fetch_count,
    input  logic [31:0]      fetch_instr0,
    input  logic [31:0]      fetch_instr1,
    input  logic [31:0]      fetch_instr2,
    output logic             fetch_ready,
    input  logic [1:0]       issue_count,
    output logic [31:0]      alpha_in,
    output logic [31:0]      beta_in,
    output logic [31:0]      gamma_in,
    output logic             alpha_valid,
    output logic             beta_valid,
    output logic             gamma_valid,
    output logic [SEQ_W-1:0] alpha_seq,
    output logic [SEQ_W-1:0] beta_seq,
    output logic [SEQ_W-1:0] gamma_seq,
    output logic [SEQ_W-1:0] global_seq_num,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_READY_MAX = CW'(DEPTH - 3);

    logic [31:0]      r_instr [DEPTH];
    logic [SEQ_W-1:0] r_seq   [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [SEQ_W-1:0] r_gseq;
    logic             r_overflow;

    logic [1:0]       w_deq;
    logic [1:0]       w_enq;
    logic [31:0]      w_fetch      [3];
    logic             w_slot_valid [3];
    logic [31:0]      w_slot_instr [3];
    logic [SEQ_W-1:0] w_slot_seq   [3];

    // Ready depends only on the registered count, never on this cycle's issue.
    assign fetch_ready = (r_count <= c_READY_MAX);
    assign w_enq       = fetch_ready ? fetch_count : 2'd0;
    assign w_fetch[0]  = fetch_instr0;
    assign w_fetch[1]  = fetch_instr1;
    assign w_fetch[2]  = fetch_instr2;

    // Over-issue is clamped to the number of occupied entries.
    always_comb begin
        w_deq = issue_count;
        if ({{(CW-2){1'b0}}, issue_count} > r_count) begin
            w_deq = r_count[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int i = 0; i < 3; i++) begin
                if (2'(i) < w_enq) begin
                    r_instr[r_tail + AW'(i)] <= w_fetch[i];
                    r_seq[r_tail + AW'(i)]   <= r_gseq + SEQ_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_gseq     <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            // Sequence counter survives a flush so tags remain monotonic.
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_deq);
            r_tail  <= r_tail + AW'(w_enq);
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
            r_gseq  <= r_gseq + SEQ_W'(w_enq);
            if ((fetch_count != 2'd0) && !fetch_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_slot
        logic [AW-1:0] w_idx;
        assign w_idx           = r_head + AW'(k);
        assign w_slot_valid[k] = (r_count > CW'(k));
        assign w_slot_instr[k] = w_slot_valid[k] ? r_instr[w_idx] : 32'h0;
        assign w_slot_seq[k]   = w_slot_valid[k] ? r_seq[w_idx]   : '0;
    end

    assign alpha_in       = w_slot_instr[0];
    assign beta_in        = w_slot_instr[1];
    assign gamma_in       = w_slot_instr[2];
    assign alpha_valid    = w_slot_valid[0];
    assign beta_valid     = w_slot_valid[1];
    assign gamma_valid    = w_slot_valid[2];
    assign alpha_seq      = w_slot_seq[0];
    assign beta_seq       = w_slot_seq[1];
    assign gamma_seq      = w_slot_seq[2];
    assign global_seq_num = r_gseq;
    assign overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_superscalar_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_superscalar_issue_queue
//  Description : Randomized and directed bench against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_superscalar_issue_queue;

    localparam int c_DEPTH = 8;
    localparam int c_SEQ_W = 16;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [1:0]  fetch_count;
    logic [31:0] fetch_instr0;
    logic [31:0] fetch_instr1;
    logic [31:0] fetch_instr2;
    logic        fetch_ready;
    logic [1:0]  issue_count;
    logic [31:0] alpha_in;
    logic [31:0] beta_in;
    logic [31:0] gamma_in;
    logic        alpha_valid;
    logic        beta_valid;
    logic        gamma_valid;
    logic [15:0] alpha_seq;
    logic [15:0] beta_seq;
    logic [15:0] gamma_seq;
    logic [15:0] global_seq_num;
    logic        overflow;

    superscalar_issue_queue #(.DEPTH(c_DEPTH), .SEQ_W(c_SEQ_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .fetch_count    (fetch_count),
        .fetch_instr0   (fetch_instr0),
        .fetch_instr1   (fetch_instr1),
        .fetch_instr2   (fetch_instr2),
        .fetch_ready    (fetch_ready),
        .issue_count    (issue_count),
        .alpha_in       (alpha_in),
        .beta_in        (beta_in),
        .gamma_in       (gamma_in),
        .alpha_valid    (alpha_valid),
        .beta_valid     (beta_valid),
        .gamma_valid    (gamma_valid),
        .alpha_seq      (alpha_seq),
        .beta_seq       (beta_seq),
        .gamma_seq      (gamma_seq),
        .global_seq_num (global_seq_num),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [15:0] sq;
    } ent_t;

    ent_t        m_q[$];
    logic [15:0] m_gseq;
    logic        m_ov;

    int total;
    int bad;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] ins [3];
        logic [15:0] sq  [3];
        logic        vl  [3];
        ins[0] = alpha_in;    ins[1] = beta_in;    ins[2] = gamma_in;
        sq[0]  = alpha_seq;   sq[1]  = beta_seq;   sq[2]  = gamma_seq;
        vl[0]  = alpha_valid; vl[1]  = beta_valid; vl[2]  = gamma_valid;
        for (int k = 0; k < 3; k++) begin
            if (k < m_q.size()) begin
                check_eq($sformatf("valid%0d", k), 64'(vl[k]), 64'd1);
                check_eq($sformatf("instr%0d", k), 64'(ins[k]), 64'(m_q[k].ins));
                check_eq($sformatf("seq%0d", k), 64'(sq[k]), 64'(m_q[k].sq));
            end else begin
                check_eq($sformatf("valid%0d", k), 64'(vl[k]), 64'd0);
                check_eq($sformatf("instr%0d", k), 64'(ins[k]), 64'd0);
                check_eq($sformatf("seq%0d", k), 64'(sq[k]), 64'd0);
            end
        end
        check_eq("gseq", 64'(global_seq_num), 64'(m_gseq));
        check_eq("ready", 64'(fetch_ready), 64'((c_DEPTH - m_q.size()) >= 3));
        check_eq("overflow", 64'(overflow), 64'(m_ov));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_gseq = 16'h0;
        m_ov   = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, then check after the edge.
    task automatic step(input logic fl, input logic [1:0] fc, input logic [1:0] ic,
                        input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        logic [31:0] w [3];
        int          n_before;
        int          d;
        flush        = fl;
        fetch_count  = fc;
        issue_count  = ic;
        fetch_instr0 = w0;
        fetch_instr1 = w1;
        fetch_instr2 = w2;
        w[0] = w0; w[1] = w1; w[2] = w2;
        if (fl) begin
            m_q.delete();
        end else begin
            n_before = m_q.size();
            d = int'(ic);
            if (d > n_before) d = n_before;
            for (int i = 0; i < d; i++) void'(m_q.pop_front());
            if ((c_DEPTH - n_before) >= 3) begin
                for (int i = 0; i < int'(fc); i++) begin
                    m_q.push_back('{ins: w[i], sq: m_gseq});
                    m_gseq = m_gseq + 16'd1;
                end
            end else if (fc != 2'd0) begin
                m_ov = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic rstep(input int flush_pct);
        step(($urandom_range(99) < flush_pct), 2'($urandom_range(3)), 2'($urandom_range(3)),
             $urandom(), $urandom(), $urandom());
    endtask

    initial begin
        total = 0;
        bad   = 0;
        flush = 1'b0; fetch_count = 2'd0; issue_count = 2'd0;
        fetch_instr0 = '0; fetch_instr1 = '0; fetch_instr2 = '0;
        rst_n = 1'b0;
        model_reset();
        #12;
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Directed sequence from the basic scenarios.
        step(1'b0, 2'd3, 2'd0, 32'h8C220004, 32'h00431020, 32'hAC250008);
        step(1'b0, 2'd0, 2'd1, 32'h0, 32'h0, 32'h0);
        step(1'b0, 2'd0, 2'd3, 32'h0, 32'h0, 32'h0);
        step(1'b0, 2'd3, 2'd0, $urandom(), $urandom(), $urandom());
        step(1'b0, 2'd3, 2'd0, $urandom(), $urandom(), $urandom());
        step(1'b0, 2'd2, 2'd0, $urandom(), $urandom(), 32'h0);
        step(1'b0, 2'd3, 2'd2, $urandom(), $urandom(), $urandom());
        step(1'b0, 2'd3, 2'd3, $urandom(), $urandom(), $urandom());
        step(1'b0, 2'd3, 2'd3, $urandom(), $urandom(), $urandom());
        step(1'b0, 2'd2, 2'd2, $urandom(), $urandom(), $urandom());
        step(1'b1, 2'd3, 2'd1, $urandom(), $urandom(), $urandom());
        step(1'b0, 2'd3, 2'd0, $urandom(), $urandom(), $urandom());

        for (int i = 0; i < 400; i++) rstep(4);

        // Run the tag counter up to the wrap point with full-rate traffic.
        while (m_gseq < 16'hFFF0) begin
            step(1'b0, 2'd3, 2'd3, $urandom(), $urandom(), $urandom());
        end
        step(1'b0, 2'd0, 2'd3, 32'h0, 32'h0, 32'h0);
        step(1'b0, 2'd0, 2'd3, 32'h0, 32'h0, 32'h0);
        step(1'b0, 2'd0, 2'd3, 32'h0, 32'h0, 32'h0);
        while (m_gseq != 16'hFFFE) begin
            step(1'b0, 2'd1, 2'd3, $urandom(), 32'h0, 32'h0);
        end
        step(1'b0, 2'd0, 2'd3, 32'h0, 32'h0, 32'h0);
        step(1'b0, 2'd3, 2'd0, $urandom(), $urandom(), $urandom());
        check_eq("wrap_gseq", 64'(global_seq_num), 64'h0001);
        for (int i = 0; i < 100; i++) rstep(3);

        // Asynchronous reset between clock edges.
        step(1'b0, 2'd3, 2'd0, $urandom(), $urandom(), $urandom());
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("async_valid", 64'(alpha_valid), 64'd0);
        check_eq("async_instr", 64'(alpha_in), 64'd0);
        check_eq("async_gseq", 64'(global_seq_num), 64'd0);
        check_eq("async_ready", 64'(fetch_ready), 64'd1);
        #1 rst_n = 1'b1;
        flush = 1'b0; fetch_count = 2'd0; issue_count = 2'd0;
        @(negedge clk);
        check_outputs();
        for (int i = 0; i < 100; i++) rstep(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/superscalar_issue_queue.md
Name: superscalar_issue_queue

Overview:
In-order instruction buffer between fetch and superscalar_decode_hazard. Accepts up to 3 fetched words per cycle and tags each with a 16-bit program-order sequence number. Presents the three oldest entries on the alpha/beta/gamma decode ports and retires however many the hazard stage consumes each cycle. Absorbs stalls: unconsumed entries stay queued and are re-presented next cycle.

Parameters:
DEPTH, 8, queue entries; power of two, minimum 4
SEQ_W, 16, sequence-number width; matches global_seq_num in decode

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard all queued entries (branch/jump redirect)
fetch_count  in  2  number of valid fetch words this cycle, 0..3
fetch_instr0  in  32  oldest fetched word
fetch_instr1  in  32  second fetched word
fetch_instr2  in  32  third fetched word
fetch_ready  out  1  queue can accept 3 words this cycle
issue_count  in  2  number of presented instructions consumed by decode this cycle, oldest first
alpha_in  out  32  oldest entry, or 32'h0 (NOP)
beta_in  out  32  second entry, or 32'h0
gamma_in  out  32  third entry, or 32'h0
alpha_valid, beta_valid, gamma_valid  out  1 each  slot holds a real entry
alpha_seq, beta_seq, gamma_seq  out  SEQ_W each  sequence tag of slot, 0 when invalid
global_seq_num  out  SEQ_W  next sequence number to be assigned
overflow  out  1  sticky: fetch words arrived while fetch_ready=0

Behaviour:
- Storage: circular buffer of DEPTH entries {instr[31:0], seq[SEQ_W-1:0]}; head, tail registers of log2(DEPTH) bits; count register of log2(DEPTH)+1 bits.
- Reset (rst_n low, asynchronous): head=tail=count=0, global_seq_num=0, overflow=0. All slot outputs read 0/invalid. fetch_ready=1.
- fetch_ready = (DEPTH - count) >= 3. It is combinational from registered count only, with no dependence on the same-cycle issue_count.
- Presentation is combinational from registers:
  - slot k (alpha=0, beta=1, gamma=2) is valid iff count > k;
  - a valid slot drives buffer[(head+k) mod DEPTH];
  - an invalid slot drives instr 32'h0 and seq 0.
- Dequeue: deq = min(issue_count, count, 3). An excess issue_count is clamped silently. head advances by deq mod DEPTH.
- Enqueue: enq = fetch_count when fetch_ready=1, else 0.
  - Word i is written to buffer[(tail+i) mod DEPTH] with seq = global_seq_num + i (mod 2^SEQ_W).
  - tail advances by enq; global_seq_num advances by enq, wrapping mod 2^SEQ_W.
- Simultaneous enqueue and dequeue: count_next = count + enq - deq. fetch_ready is judged on pre-dequeue count, so count never exceeds DEPTH.
- Overflow: fetch_count != 0 while fetch_ready=0 drops all words, leaves global_seq_num unchanged, and sets overflow. overflow clears only on reset.
- Flush (synchronous) has priority over enqueue and dequeue in the same cycle:
  - head=tail=count=0;
  - incoming fetch words are dropped and overflow is not set;
  - global_seq_num is not reset, so post-flush tags stay monotonic.
- Next-cycle state: slots reflect the post-update buffer one cycle after any enqueue/dequeue. Latency from fetch to alpha presentation is 1 cycle when the queue was empty.
- In-order guarantee: slot order always equals sequence order, and alpha_seq < beta_seq < gamma_seq modulo wrap.
- Reset asserted mid-operation clears everything immediately, independent of clk.

Test Plan:
- Reset then fetch_count=3 with words 0x8C220004, 0x00431020, 0xAC250008, issue_count=0 -> next cycle alpha/beta/gamma show those words, seqs 0/1/2, global_seq_num=3, count=3.
- Partial consume: state above, issue_count=1, fetch_count=0 -> next cycle alpha=0x00431020 (seq 1), beta=0xAC250008 (seq 2), gamma=0 invalid.
- Full/overflow with DEPTH=8:
  - enqueue 3+3 with no issue -> count=6, fetch_ready=0;
  - fetch_count=2 -> words dropped, overflow=1, global_seq_num stays 6;
  - issue_count=3 -> fetch_ready=1 the following cycle.
- Simultaneous: count=6, fetch_ready=0, issue_count=2, fetch_count=3 -> fetch dropped, count=4. Next cycle enq 3 with issue 3 -> count=4, head/tail wrap correctly past index 7.
- Seq wrap: preload global_seq_num to 0xFFFE via repeated fetch/issue, fetch 3 -> tags 0xFFFE, 0xFFFF, 0x0000, global_seq_num=0x0001.
- Flush: queue holds 5 entries, flush=1 with fetch_count=3 -> next cycle all slots invalid, count=0, global_seq_num unchanged, overflow unchanged. Async rst_n pulse mid-burst -> outputs zero before next clk edge.
